// File: rtl/spi_vga_pkg.sv
// Shared definitions for the SPI-to-VRAM frame path: decoder state encodings and frame constants.
// FRAME_CHECKSUM_EN adds the trailing checksum state.
package spi_vga_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         HDR_LEN           = 3;

    // Header states occupy encodings 1..HDR_LEN so the payload state follows directly after them.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR_HI  = 3'd1,
        ST_HDR_LO  = 3'd2,
        ST_HDR_LEN = 3'(HDR_LEN),
        ST_DATA    = 3'(HDR_LEN + 1)
`ifdef FRAME_CHECKSUM_EN
        ,
        ST_CHK     = 3'(HDR_LEN + 2)
`endif
    } dec_state_t;

endpackage

// File: rtl/spi_frame_decoder_byte_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags expiry
// once TIMEOUT_CYCLES-1 cycles have elapsed.
module byte_timeout #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int                CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign expired = enable && (cnt == LIMIT);

    // Saturates at the limit so a stalled consumer never sees the count wrap back to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_frame_decoder.sv
// Turns the SPI slave byte stream into addressed VRAM write bursts with resync and inter-byte timeout.
// Optional trailing XOR checksum is enabled by defining FRAME_CHECKSUM_EN.
//
// state      | meaning
// ST_IDLE    | hunting for SYNC_BYTE, other bytes dropped
// ST_HDR_HI  | next byte supplies address bits [ADDR_WIDTH-1:8]
// ST_HDR_LO  | next byte supplies address bits [7:0]
// ST_HDR_LEN | next byte supplies payload length (0 = 256)
// ST_DATA    | each byte becomes one VRAM write
// ST_CHK     | next byte is compared against the running XOR
module spi_frame_decoder
    import spi_vga_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 11,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int          TIMEOUT_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_err
);

    dec_state_t            state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [8:0]            remaining;
    logic                  tmo_expired;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]            chk_acc;
`endif

    assign busy = (state != ST_IDLE);

    // Clearing while idle keeps the count at zero so every frame starts with a full window.
    byte_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (rx_valid || !busy),
        .enable (busy),
        .expired(tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            remaining  <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            chk_acc    <= '0;
`endif
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            // A byte arriving in the expiry cycle takes priority over the timeout.
            if (rx_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            state <= ST_HDR_HI;
                        end
                    end
                    ST_HDR_HI: begin
                        ptr[ADDR_WIDTH-1:8] <= rx_data[ADDR_WIDTH-9:0];
`ifdef FRAME_CHECKSUM_EN
                        chk_acc <= rx_data;
`endif
                        state <= ST_HDR_LO;
                    end
                    ST_HDR_LO: begin
                        ptr[7:0] <= rx_data;
`ifdef FRAME_CHECKSUM_EN
                        chk_acc <= chk_acc ^ rx_data;
`endif
                        state <= ST_HDR_LEN;
                    end
                    ST_HDR_LEN: begin
                        remaining <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
`ifdef FRAME_CHECKSUM_EN
                        chk_acc <= chk_acc ^ rx_data;
`endif
                        state <= ST_DATA;
                    end
                    ST_DATA: begin
                        wr_en     <= 1'b1;
                        wr_addr   <= ptr;
                        wr_data   <= rx_data;
                        ptr       <= ptr + ADDR_WIDTH'(1);
                        remaining <= remaining - 9'd1;
`ifdef FRAME_CHECKSUM_EN
                        chk_acc <= chk_acc ^ rx_data;
                        if (remaining == 9'd1) begin
                            state <= ST_CHK;
                        end
`else
                        if (remaining == 9'd1) begin
                            state      <= ST_IDLE;
                            frame_done <= 1'b1;
                        end
`endif
                    end
`ifdef FRAME_CHECKSUM_EN
                    ST_CHK: begin
                        state <= ST_IDLE;
                        if (rx_data == chk_acc) begin
                            frame_done <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
`endif
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end else if (tmo_expired) begin
                state     <= ST_IDLE;
                frame_err <= 1'b1;
            end
        end
    end

endmodule
